// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, reset PC and FSM encoding for instruction fetch
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int              c_ADDR_W   = 16;
    localparam int              c_INSTR_W  = 16;
    localparam logic [15:0]     c_RESET_PC = 16'd0;
    localparam int              c_PC_STEP  = 1;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t    c_ST_FETCH = 1'b0;
    localparam fetch_state_t    c_ST_DROP  = 1'b1;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : 2-entry {pc, instr} FIFO; entry 0 is always the head so the
//               head outputs come straight from registers
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int INSTR_W = c_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [ADDR_W-1:0]  r_pc0;
    logic [ADDR_W-1:0]  r_pc1;
    logic [INSTR_W-1:0] r_instr0;
    logic [INSTR_W-1:0] r_instr1;
    logic [1:0]         r_count;
    logic               w_push_to_head;

    // A push lands in the head slot when the FIFO is, or is about to become, empty
    assign w_push_to_head = (r_count == 2'd0) || ((r_count == 2'd1) && pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc0    <= '0;
            r_pc1    <= '0;
            r_instr0 <= '0;
            r_instr1 <= '0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_count  <= 2'd0;
        end else begin
            if (pop) begin
                r_pc0    <= r_pc1;
                r_instr0 <= r_instr1;
            end
            if (push) begin
                if (w_push_to_head) begin
                    r_pc0    <= push_pc;
                    r_instr0 <= push_instr;
                end else begin
                    r_pc1    <= push_pc;
                    r_instr1 <= push_instr;
                end
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count      = r_count;
    assign head_pc    = r_pc0;
    assign head_instr = r_instr0;

endmodule : fetch_buf
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch sequencer - PC, memory req/ack, redirect/drop FSM,
//               and a 2-deep buffer presenting instructions to decode
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                INSTR_W  = c_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC),
    parameter int                PC_STEP  = c_PC_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc
);

    localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(PC_STEP);

    fetch_state_t       r_state;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [ADDR_W-1:0]  r_pc;

    logic [1:0]         w_count;
    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_occ_next;
    logic [ADDR_W-1:0]  w_next_addr;

    assign w_xfer      = r_mem_req && mem_ack;
    assign w_push      = w_xfer && (r_state == c_ST_FETCH) && !redirect;
    assign w_pop       = ir_valid && ir_ready && !redirect;
    assign w_occ_next  = w_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_next_addr = r_mem_addr + c_STEP;

    // r_pc is the pending fetch PC; it only differs from r_mem_addr in DROP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_FETCH;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_pc       <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
            if (!r_mem_req || mem_ack) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= redirect_pc;
                r_state    <= c_ST_FETCH;
            end else begin
                r_state    <= c_ST_DROP;
            end
        end else if (r_state == c_ST_DROP) begin
            if (mem_ack) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= r_pc;
                r_state    <= c_ST_FETCH;
            end
        end else begin
            if (w_xfer) begin
                r_mem_addr <= w_next_addr;
                r_pc       <= w_next_addr;
            end
            // Keep one slot free for the response of any request in flight
            r_mem_req <= (w_occ_next < 2'd2);
        end
    end

    fetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_fetch_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_pc    (r_mem_addr),
        .push_instr (mem_rdata),
        .pop        (w_pop),
        .flush      (redirect),
        .count      (w_count),
        .head_pc    (ir_pc),
        .head_instr (ir_data)
    );

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign ir_valid = (w_count != 2'd0);

endmodule : instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 16-bit datapath. It owns the fetch-side program counter and reads instructions from instruction memory over a req/ack handshake. Fetched words go into a 2-entry buffer, and each is presented to decode with its PC over a valid/ready handshake. Redirects from branch/jump resolution replace the PC and discard stale fetches.

## Interface
Parameters:
- ADDR_W, 16, PC and memory address width
- INSTR_W, 16, instruction word width
- RESET_PC, 16'd0, first fetch address after reset
- PC_STEP, 1, PC increment per instruction (word addressing)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_req  output  1  fetch request to instruction memory
- mem_addr  output  ADDR_W  fetch address, stable while mem_req high
- mem_ack  input  1  memory accepts and completes the current request this cycle
- mem_rdata  input  INSTR_W  instruction word, valid only when mem_ack is high
- redirect  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  ADDR_W  new PC, valid when redirect is high
- ir_valid  output  1  ir_data/ir_pc hold a valid instruction
- ir_ready  input  1  decode accepts the instruction
- ir_data  output  INSTR_W  instruction at buffer head
- ir_pc  output  ADDR_W  address of ir_data

## Operation
- All outputs are registered.
- Reset values: mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir_data=0, ir_pc=0. Internal fetch PC is RESET_PC and the buffer is empty.
- At most one request is outstanding. A transfer completes on a clock edge where mem_req and mem_ack are both high. mem_addr must not change while mem_req is high and no ack has arrived.
- Issue rule: a request is issued or kept only while occupancy after this edge plus 1 is ≤ 2.
- On a completed transfer:
  - Push {mem_addr, mem_rdata} into the buffer.
  - Advance the fetch PC to mem_addr + PC_STEP, mod 2^ADDR_W. 0xFFFF wraps to 0x0000.
  - If the issue rule holds, keep mem_req high with the new address.
- Buffer: 2-entry FIFO. ir_valid is high when the FIFO is non-empty, and the head drives ir_data/ir_pc. A pop occurs when ir_valid && ir_ready. Push and pop may happen on the same edge.
- FSM states:
  - FETCH: normal operation.
  - DROP: an outstanding request is being abandoned.
- redirect (highest priority):
  - Flush the buffer and ignore a simultaneous pop.
  - Load the fetch PC with redirect_pc.
  - If no request is outstanding, or an ack arrives on the same edge, discard that data. Next cycle: mem_req=1, mem_addr=redirect_pc, state FETCH.
  - If a request is outstanding without an ack, keep mem_req and mem_addr unchanged and go to DROP.
- DROP:
  - On ack, discard mem_rdata and issue redirect_pc next cycle, returning to FETCH.
  - A further redirect while in DROP overwrites the pending PC.
- Asserting rst_n low mid-transfer returns every output to its reset value immediately; an in-flight ack is lost.

## Timing
- First request: mem_req rises on the first rising edge with rst_n high, with mem_addr=RESET_PC.
- Fetch latency: with the ack in the cycle mem_req is high and the buffer empty, ir_valid rises on that same ack edge.
- Throughput: with a zero-wait memory (ack held high) and ir_ready held high, one instruction per cycle and mem_req stays high continuously.
- Backpressure: with ir_ready low, after two completed transfers mem_req drops on the second ack edge. It re-asserts on the edge after the first pop.
- Redirect penalty: mem_req carries redirect_pc one cycle after the redirect edge, or one cycle after the drop ack. No instruction from the old path may appear on ir_* after the redirect edge.

## Structure
- Shared package (fetch_pkg): ADDR_W/INSTR_W defaults, RESET_PC, and the FSM state enum {FETCH, DROP}.
- One sub-module, fetch_buf: 2-entry FIFO holding {pc, instr}. Ports: push, pop, flush, count, head. The top level holds the FSM, PC and request logic.

## Test plan
- Reset then zero-wait memory with mem_rdata = addr+0x100 and ir_ready=1 → ir_pc sequence 0,1,2,3; ir_data 0x100..0x103 on consecutive cycles; mem_req stays high.
- ir_ready=0 for 5 cycles → exactly two instructions buffered (PC 0,1), mem_req low, mem_addr=2. Raise ir_ready → PC 0,1,2 delivered in order with none lost or duplicated.
- Memory with 3-cycle ack latency and redirect to 0x0040 while the request for 0x0005 is outstanding → mem_addr holds 0x0005 until the ack, and that data is dropped. The next request is 0x0040 and the first ir_pc after the redirect is 0x0040.
- Redirect on the same edge as an ack and a pop → the buffer is empty after the edge, and the next mem_addr is redirect_pc.
- Redirect to 0xFFFF → ir_pc sequence 0xFFFF, 0x0000, 0x0001.
- rst_n pulsed low while mem_req is high → all outputs return to their reset values asynchronously, and the fetch restarts at RESET_PC.
